// File: rtl/fs_bist_pkg.sv
// Shared types, constants and the golden full-subtractor equation for the BIST checker.
package fs_bist_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    CHECK,
    DONE
  } state_t;

  localparam int unsigned NUM_VECTORS = 8;

  // Returns {D, Bout} for a - b - bin.
  function automatic logic [1:0] fs_golden_f(input logic a, input logic b, input logic bin);
    logic d;
    logic bout;
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~a & bin) | (b & bin);
    return {d, bout};
  endfunction

endpackage

// File: rtl/fs_golden.sv
// Combinational golden full-subtractor, isolating the expected-response path.
module fs_golden
  import fs_bist_pkg::*;
(
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);

  assign {o_d, o_bout} = fs_golden_f(i_a, i_b, i_bin);

endmodule

// File: rtl/fs_bist_checker.sv
// BIST sequencer and response checker for a full_subtractor cell: walks all eight
// {a,b,Bin} vectors, compares the cell's D/Bout with the golden model and reports results.
module fs_bist_checker
  import fs_bist_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned ERR_CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 a_o,
  output logic                 b_o,
  output logic                 bin_o,
  input  logic                 d_i,
  input  logic                 bout_i,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 first_err_valid,
  output logic [2:0]           first_err_vec
);

  localparam int unsigned CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [2:0]       IDX_LAST = 3'(NUM_VECTORS - 1);

  state_t                r_state;
  logic [2:0]            r_idx;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_busy;
  logic                  r_done;
  logic [ERR_CNT_W-1:0]  r_err_count;
  logic                  r_first_err_valid;
  logic [2:0]            r_first_err_vec;

  logic                  w_gold_d;
  logic                  w_gold_bout;
  logic                  w_mismatch;

  fs_golden u_golden (
    .i_a    (r_idx[2]),
    .i_b    (r_idx[1]),
    .i_bin  (r_idx[0]),
    .o_d    (w_gold_d),
    .o_bout (w_gold_bout)
  );

  assign w_mismatch = (d_i != w_gold_d) || (bout_i != w_gold_bout);

  // Sequencer FSM: vector drive, settle count, response check and result latching.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state           <= IDLE;
      r_idx             <= '0;
      r_cnt             <= '0;
      r_busy            <= 1'b0;
      r_done            <= 1'b0;
      r_err_count       <= '0;
      r_first_err_valid <= 1'b0;
      r_first_err_vec   <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state           <= DRIVE;
            r_idx             <= '0;
            r_cnt             <= '0;
            r_busy            <= 1'b1;
            r_done            <= 1'b0;
            r_err_count       <= '0;
            r_first_err_valid <= 1'b0;
            r_first_err_vec   <= '0;
          end
        end
        DRIVE: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_state <= CHECK;
          end
        end
        CHECK: begin
          if (w_mismatch) begin
            if (r_err_count != '1) begin
              r_err_count <= r_err_count + 1'b1;
            end
            if (!r_first_err_valid) begin
              r_first_err_valid <= 1'b1;
              r_first_err_vec   <= r_idx;
            end
          end
          if (r_idx == IDX_LAST) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_cnt   <= '0;
            r_state <= DRIVE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign {a_o, b_o, bin_o} = r_idx;
  assign busy              = r_busy;
  assign done              = r_done;
  assign err_count         = r_err_count;
  assign first_err_valid   = r_first_err_valid;
  assign first_err_vec     = r_first_err_vec;
  assign pass              = r_done && (r_err_count == '0);

endmodule

// File: tb/tb_fs_bist_checker.sv
// Randomized self-checking bench: three checker instances (default, ERR_CNT_W=2,
// SETTLE_CYCLES=3), each paired with a full_subtractor model that can be faulted.
module tb_fs_bist_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;

  always #5 clk = ~clk;

  logic       a [3];
  logic       b [3];
  logic       bi [3];
  logic       d [3];
  logic       bo [3];
  logic       busy [3];
  logic       done [3];
  logic       pass [3];
  logic       fev [3];
  logic [2:0] fvec [3];
  logic [3:0] e0;
  logic [1:0] e1;
  logic [3:0] e2;

  int         mode [3];
  logic [7:0] md [3];
  logic [7:0] mb [3];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference subtractor from plain arithmetic: a - b - bin.
  function automatic logic [1:0] fs_ref(input int v);
    int x, y, z, diff;
    x = (v >> 2) & 1;
    y = (v >> 1) & 1;
    z = v & 1;
    diff = x - y - z;
    return {logic'(diff & 1), logic'(diff < 0)};
  endfunction

  // Cell under test: 0 correct, 1 Bout stuck 0, 2 D inverted, 3 random per-vector flips.
  function automatic logic [1:0] cell_model(input int m, input logic [7:0] fd,
                                            input logic [7:0] fb, input int v);
    logic [1:0] g;
    g = fs_ref(v);
    case (m)
      1:       return {g[1], 1'b0};
      2:       return {~g[1], g[0]};
      3:       return {g[1] ^ fd[v], g[0] ^ fb[v]};
      default: return g;
    endcase
  endfunction

  always_comb {d[0], bo[0]} = cell_model(mode[0], md[0], mb[0], int'({a[0], b[0], bi[0]}));
  always_comb {d[1], bo[1]} = cell_model(mode[1], md[1], mb[1], int'({a[1], b[1], bi[1]}));
  always_comb {d[2], bo[2]} = cell_model(mode[2], md[2], mb[2], int'({a[2], b[2], bi[2]}));

  fs_bist_checker u0 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_o(a[0]), .b_o(b[0]), .bin_o(bi[0]), .d_i(d[0]), .bout_i(bo[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(e0),
    .first_err_valid(fev[0]), .first_err_vec(fvec[0])
  );

  fs_bist_checker #(.SETTLE_CYCLES(1), .ERR_CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_o(a[1]), .b_o(b[1]), .bin_o(bi[1]), .d_i(d[1]), .bout_i(bo[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(e1),
    .first_err_valid(fev[1]), .first_err_vec(fvec[1])
  );

  fs_bist_checker #(.SETTLE_CYCLES(3), .ERR_CNT_W(4)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_o(a[2]), .b_o(b[2]), .bin_o(bi[2]), .d_i(d[2]), .bout_i(bo[2]),
    .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_count(e2),
    .first_err_valid(fev[2]), .first_err_vec(fvec[2])
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int get_err(input int i);
    case (i)
      0:       return int'(e0);
      1:       return int'(e1);
      default: return int'(e2);
    endcase
  endfunction

  function automatic int sat_of(input int i);
    return (i == 1) ? 3 : 15;
  endfunction

  function automatic int latency_of(input int i);
    return (i == 2) ? 8 * (3 + 1) : 8 * (1 + 1);
  endfunction

  function automatic int exp_errs(input int i);
    int n;
    n = 0;
    for (int v = 0; v < 8; v++)
      if (cell_model(mode[i], md[i], mb[i], v) != fs_ref(v)) n++;
    return (n > sat_of(i)) ? sat_of(i) : n;
  endfunction

  function automatic int exp_first(input int i);
    for (int v = 0; v < 8; v++)
      if (cell_model(mode[i], md[i], mb[i], v) != fs_ref(v)) return v;
    return -1;
  endfunction

  // One run on all three instances; extra > 0 pulses start again before edge extra+1 (mid-run).
  task automatic run(input int extra);
    int at [3];
    int cyc;
    int f;
    at = '{-1, -1, -1};
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("u%0d accept_busy_done_fev", i), int'({busy[i], done[i], fev[i]}), 4);
      check($sformatf("u%0d accept_err_clear", i), get_err(i), 0);
    end
    cyc = 0;
    while ((at[0] < 0 || at[1] < 0 || at[2] < 0) && cyc < 60) begin
      @(negedge clk) start = (cyc + 1 == extra);
      @(posedge clk);
      #1 start = 1'b0;
      cyc++;
      for (int i = 0; i < 3; i++)
        if (at[i] < 0 && done[i]) at[i] = cyc;
    end
    for (int i = 0; i < 3; i++) begin
      f = exp_first(i);
      check($sformatf("u%0d done_latency", i), at[i], latency_of(i));
      check($sformatf("u%0d err_count", i), get_err(i), exp_errs(i));
      check($sformatf("u%0d first_err_valid", i), int'(fev[i]), (f >= 0) ? 1 : 0);
      check($sformatf("u%0d first_err_vec", i), int'(fvec[i]), (f >= 0) ? f : 0);
      check($sformatf("u%0d pass", i), int'(pass[i]), (f < 0) ? 1 : 0);
      check($sformatf("u%0d done_busy", i), int'({done[i], busy[i]}), 2);
      check($sformatf("u%0d vec_hold", i), int'({a[i], b[i], bi[i]}), 7);
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s u%0d outputs", tag, i),
            int'({a[i], b[i], bi[i], busy[i], done[i], pass[i], fev[i], fvec[i]}), 0);
      check($sformatf("%s u%0d err_count", tag, i), get_err(i), 0);
    end
  endtask

  initial begin
    int extra;
    for (int i = 0; i < 3; i++) begin
      mode[i] = 0;
      md[i] = '0;
      mb[i] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    // Clean cells everywhere.
    run(0);

    // Bout stuck at 0 / D inverted with 2-bit counter / clean at long settle.
    mode[0] = 1; mode[1] = 2; mode[2] = 0;
    run(0);
    check("stuck_bout err_count_const", int'(e0), 4);
    check("stuck_bout first_vec_const", int'(fvec[0]), 1);
    check("d_inv saturated_const", int'(e1), 3);

    // Ignored mid-run start at cycle 5; the run also starts from DONE.
    run(4);

    // Asynchronous reset mid-run, then a clean run.
    mode[0] = 2; mode[1] = 1; mode[2] = 3; md[2] = 8'hA5; mb[2] = 8'h3C;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) mode[i] = 0;
    run(0);

    // Randomized fault patterns, some with an ignored start pulse.
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 3; i++) begin
        mode[i] = int'($urandom_range(0, 3));
        md[i] = 8'($urandom);
        mb[i] = 8'($urandom);
      end
      extra = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 14)) : 0;
      run(extra);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
